// File: rtl/cam_pkg.sv
// Shared types and constants for the camera sensor emulator.
// Holds the frame-sequencer state encoding, the RGB565 colour-bar palette
// and the line-length helper used to size the horizontal counter.
package cam_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VSYNC  = 3'd1,
      VBP    = 3'd2,
      ACTIVE = 3'd3,
      VFP    = 3'd4
   } cam_state_e;

   // RGB565 colour bars, left to right
   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   // PCLK cycles per line: two bytes per pixel plus horizontal blank
   function automatic int line_cycles(input int h_active, input int h_blank);
      return 2 * h_active + h_blank;
   endfunction

   // Colour of bar number idx (0 = leftmost)
   function automatic logic [15:0] bar_color(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cam_emu_pattern.sv
// Pixel value generator for the camera emulator.
// Default build: pixel = (x + y + frame) mod 2^16, a moving counter ramp.
// With CAM_EMU_COLORBAR_EN defined: eight equal-width vertical RGB565 bars.
module cam_emu_pattern
   import cam_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int X_W      = 10,
   parameter int Y_W      = 9
) (
   input  logic [X_W-1:0] i_x,
   input  logic [Y_W-1:0] i_y,
   input  logic [15:0]    i_frame,
   output logic [15:0]    o_pixel
);

`ifdef CAM_EMU_COLORBAR_EN
   localparam int BAR_W = H_ACTIVE / 8;

   logic [X_W-1:0] bar_idx;
   logic           unused_pattern_inputs;

   // Bar number from column; H_ACTIVE is a multiple of 8 so bars are 0..7
   assign bar_idx = i_x / X_W'(BAR_W);
   assign o_pixel = bar_color(bar_idx[2:0]);

   // Bars are static: row, frame and upper bar-index bits do not matter
   assign unused_pattern_inputs = ^{i_y, i_frame, bar_idx};
`else
   // Counter ramp wraps naturally in 16 bits
   assign o_pixel = 16'(i_x) + 16'(i_y) + i_frame;
`endif

endmodule

// File: rtl/cam_emulator.sv
// OV7670-style camera sensor emulator.
// Generates VSYNC / HREF / 8-bit data timing for RGB565 frames, one byte per
// PCLK (i_clk). Frames run VSYNC -> VBP -> ACTIVE -> VFP, either once per
// i_start pulse or back-to-back while i_continuous is held at VFP end.
// Optional feature: define CAM_EMU_COLORBAR_EN to output colour bars instead
// of the default counter ramp.
// All outputs are registered and decoded from next-state values so that the
// first HREF cycle already carries pixel (0,0) high byte.
module cam_emulator
   import cam_pkg::*;
#(
   parameter int H_ACTIVE    = 640,
   parameter int H_BLANK     = 144,
   parameter int V_ACTIVE    = 480,
   parameter int VSYNC_LINES = 3,
   parameter int VBP_LINES   = 17,
   parameter int VFP_LINES   = 10
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_continuous,
   output logic        o_vsync,
   output logic        o_href,
   output logic [7:0]  o_data,
   output logic        o_sof,
   output logic        o_busy,
   output logic [15:0] o_frame_cnt
);

   localparam int LINE_CYCLES = line_cycles(H_ACTIVE, H_BLANK);
   localparam int MAX_A       = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
   localparam int MAX_B       = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
   localparam int MAX_LINES   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int COL_W       = (LINE_CYCLES > 1) ? $clog2(LINE_CYCLES) : 1;
   localparam int LINE_W      = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
   localparam int X_W         = $clog2(H_ACTIVE);

   localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(LINE_CYCLES - 1);
   localparam logic [COL_W-1:0]  HREF_END    = COL_W'(2 * H_ACTIVE);
   localparam logic [LINE_W-1:0] VSYNC_LAST  = LINE_W'(VSYNC_LINES - 1);
   localparam logic [LINE_W-1:0] VBP_LAST    = LINE_W'(VBP_LINES - 1);
   localparam logic [LINE_W-1:0] ACTIVE_LAST = LINE_W'(V_ACTIVE - 1);
   localparam logic [LINE_W-1:0] VFP_LAST    = LINE_W'(VFP_LINES - 1);

   cam_state_e        state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic [15:0]       frame_q, frame_d;
   logic [LINE_W-1:0] region_last;
   logic              last_col;
   logic              last_line;

   logic              vsync_q, href_q, sof_q, busy_q;
   logic [7:0]        data_q;
   logic              href_d, sof_d;
   logic [7:0]        data_d;
   logic [15:0]       pixel;

   // Next-state: walk columns within a line, lines within a region, then regions
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      line_d      = line_q;
      frame_d     = frame_q;
      region_last = '0;
      case (state_q)
         VSYNC:   region_last = VSYNC_LAST;
         VBP:     region_last = VBP_LAST;
         ACTIVE:  region_last = ACTIVE_LAST;
         VFP:     region_last = VFP_LAST;
         default: region_last = '0;
      endcase
      last_col  = (col_q == COL_LAST);
      last_line = (line_q == region_last);

      if (state_q == IDLE) begin
         col_d  = '0;
         line_d = '0;
         if (i_start) begin
            state_d = VSYNC;
         end
      end else if (last_col) begin
         col_d = '0;
         if (last_line) begin
            line_d = '0;
            case (state_q)
               VSYNC:  state_d = VBP;
               VBP:    state_d = ACTIVE;
               ACTIVE: state_d = VFP;
               VFP: begin
                  // Frame complete; continuous mode is only honoured here
                  frame_d = frame_q + 16'd1;
                  state_d = i_continuous ? VSYNC : IDLE;
               end
               default: state_d = IDLE;
            endcase
         end else begin
            line_d = line_q + 1'b1;
         end
      end else begin
         col_d = col_q + 1'b1;
      end
   end

   // State and position registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         line_q  <= '0;
         frame_q <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         line_q  <= line_d;
         frame_q <= frame_d;
      end
   end

   cam_emu_pattern #(
      .H_ACTIVE (H_ACTIVE),
      .X_W      (X_W),
      .Y_W      (LINE_W)
   ) u_pattern (
      .i_x     (col_d[X_W:1]),
      .i_y     (line_d),
      .i_frame (frame_q),
      .o_pixel (pixel)
   );

   // Output decode from next position: even column = high byte, odd = low byte
   always_comb begin
      href_d = (state_d == ACTIVE) && (col_d < HREF_END);
      sof_d  = (state_d == VSYNC) && (state_q != VSYNC);
      data_d = '0;
      if (href_d) begin
         data_d = col_d[0] ? pixel[7:0] : pixel[15:8];
      end
   end

   // Registered sensor bus and status outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         data_q  <= '0;
         sof_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         vsync_q <= (state_d == VSYNC);
         href_q  <= href_d;
         data_q  <= data_d;
         sof_q   <= sof_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   assign o_vsync     = vsync_q;
   assign o_href      = href_q;
   assign o_data      = data_q;
   assign o_sof       = sof_q;
   assign o_busy      = busy_q;
   assign o_frame_cnt = frame_q;

endmodule
